// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (5..9 data bits, parity, 1/2 stop); UART_TX_BREAK_EN adds tx_break and a BREAK state
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_enable,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          send,
`ifdef UART_TX_BREAK_EN
  input  logic                          tx_break,
`endif
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CPB = 16'(CLK_FREQ / BAUD);
`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`endif
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop, ready;
  logic [DATA_BITS-1:0] head, sh, sh_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic par, par_n, tx_n, busy_n, done_n, fin, bit_end;
  state_t state, state_n;
  assign push = send && !full;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign empty = level == '0;
  assign head = mem[rp];
  assign bit_end = cnt == CPB - 16'd1;
  always_ff @(posedge clk)
    if (push) mem[wp] <= tx_data;
  // ready lags occupancy by a cycle so a fresh push starts its frame two edges later
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      overflow <= 1'b0;
      ready <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= send && full;
      ready <= !empty && !pop;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      par <= par_n;
      tx <= tx_n;
      busy <= busy_n;
      tx_done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 16'd1;
    idx_n = idx;
    sh_n = sh;
    par_n = par;
    tx_n = tx;
    busy_n = busy;
    done_n = 1'b0;
    pop = 1'b0;
    fin = 1'b0;
    case (state)
      S_IDLE: fin = 1'b1;
      S_START:
        if (bit_end) begin
          cnt_n = '0;
          idx_n = '0;
          tx_n = sh[0];
          state_n = S_DATA;
        end
      S_DATA:
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 4'(DATA_BITS - 1)) begin
            idx_n = '0;
            tx_n = (PARITY != 0) ? par : 1'b1;
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_n = idx + 4'd1;
            sh_n = sh >> 1;
            tx_n = sh[1];
          end
        end
      S_PAR:
        if (bit_end) begin
          cnt_n = '0;
          idx_n = '0;
          tx_n = 1'b1;
          state_n = S_STOP;
        end
      S_STOP:
        if (bit_end) begin
          cnt_n = '0;
          idx_n = idx + 4'd1;
          done_n = idx == 4'(STOP_BITS - 1);
          fin = idx == 4'(STOP_BITS - 1);
        end
`ifdef UART_TX_BREAK_EN
      S_BRK:
        if (idx == '0) begin
          cnt_n = '0;
          idx_n = {3'd0, !tx_break};
          tx_n = !tx_break;
        end else begin
          fin = bit_end;
        end
`endif
      default: state_n = S_IDLE;
    endcase
    if (fin) begin
      cnt_n = '0;
      idx_n = '0;
`ifdef UART_TX_BREAK_EN
      if (tx_break) begin
        tx_n = 1'b0;
        busy_n = 1'b1;
        state_n = S_BRK;
      end else
`endif
      if (tx_enable && ready) begin
        pop = 1'b1;
        sh_n = head;
        par_n = (PARITY == 2) ? ^head : ~^head;
        tx_n = 1'b0;
        busy_n = 1'b1;
        state_n = S_START;
      end else begin
        tx_n = 1'b1;
        busy_n = 1'b0;
        state_n = S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for a default instance and a 7E2 depth-4 instance
module tb_uart_tx_fifo;
  localparam int CPB = 434;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic a_en = 1'b1, a_send = 1'b0, a_full, a_empty, a_ovf, a_tx, a_busy, a_done;
  logic [7:0] a_data = '0;
  logic [4:0] a_level;
  logic b_en = 1'b1, b_send = 1'b0, b_full, b_empty, b_ovf, b_tx, b_busy, b_done;
  logic [6:0] b_data = '0;
  logic [2:0] b_level;
`ifdef UART_TX_BREAK_EN
  logic a_brk = 1'b0, b_brk = 1'b0;
`endif
  int passed = 0, total = 0;
  logic [8:0] sb [$];
  wire tx_m = sel ? b_tx : a_tx;
  wire busy_m = sel ? b_busy : a_busy;
  wire done_m = sel ? b_done : a_done;
  always #5 clk = ~clk;
  uart_tx_fifo u_a (
    .clk(clk), .reset(reset), .tx_enable(a_en), .tx_data(a_data), .send(a_send),
`ifdef UART_TX_BREAK_EN
    .tx_break(a_brk),
`endif
    .full(a_full), .empty(a_empty), .level(a_level), .overflow(a_ovf),
    .tx(a_tx), .busy(a_busy), .tx_done(a_done));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .tx_enable(b_en), .tx_data(b_data), .send(b_send),
`ifdef UART_TX_BREAK_EN
    .tx_break(b_brk),
`endif
    .full(b_full), .empty(b_empty), .level(b_level), .overflow(b_ovf),
    .tx(b_tx), .busy(b_busy), .tx_done(b_done));
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input logic [8:0] d, input bit keep);
    if (sel) begin b_send = 1'b1; b_data = d[6:0]; end
    else begin a_send = 1'b1; a_data = d[7:0]; end
    if (keep) sb.push_back(d);
    step(1);
    a_send = 1'b0;
    b_send = 1'b0;
  endtask
  task automatic rx_frame(input int nb, input int par, input int st);
    int n = 0;
    logic [8:0] d = '0, e;
    while (tx_m !== 1'b0 && n < 20000) begin step(1); n++; end
    chk("start_seen", tx_m, 0);
    step(CPB / 2);
    chk("start_mid", tx_m, 0);
    for (int i = 0; i < nb; i++) begin step(CPB); d[i] = tx_m; end
    e = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
    chk("data", d, e);
    if (par != 0) begin
      step(CPB);
      chk("parity", tx_m, (par == 2) ? ^e : ~^e);
    end
    for (int s = 0; s < st; s++) begin step(CPB); chk("stop", tx_m, 1); end
    step(CPB - CPB / 2 - 1);
    chk("done_early", done_m, 0);
    chk("busy_frame", busy_m, 1);
    step(1);
    chk("done_pulse", done_m, 1);
  endtask
  initial begin
    step(3);
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_full", a_full, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_level", a_level, 0);
    reset = 1'b0;
    step(2);
    push(9'h55, 1);
    chk("lat_e0", a_tx, 1);
    step(1);
    chk("lat_e1_tx", a_tx, 1);
    chk("lat_e1_busy", a_busy, 0);
    step(1);
    chk("lat_e2_tx", a_tx, 0);
    chk("lat_e2_busy", a_busy, 1);
    rx_frame(8, 0, 1);
    chk("busy_fall", a_busy, 0);
    step(1);
    chk("done_single", a_done, 0);
    chk("idle_tx", a_tx, 1);
    step(5);
    push(9'hA1, 1);
    push(9'hB2, 1);
    push(9'hC3, 1);
    rx_frame(8, 0, 1);
    chk("contig1", a_tx, 0);
    chk("level_f2", a_level, 1);
    rx_frame(8, 0, 1);
    chk("contig2", a_tx, 0);
    chk("level_f3", a_level, 0);
    rx_frame(8, 0, 1);
    chk("burst_busy", a_busy, 0);
    chk("burst_empty", a_empty, 1);
    step(5);
    push(9'h12, 1);
    push(9'h34, 1);
    step(1);
    chk("mid_start", a_tx, 0);
    step(CPB * 4 + CPB / 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_tx", a_tx, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_level", a_level, 0);
    chk("mid_rst_done", a_done, 0);
    sb.delete();
    step(2 * CPB);
    chk("post_rst_tx", a_tx, 1);
    chk("post_rst_busy", a_busy, 0);
    sel = 1'b1;
    push(9'h41, 1);
    rx_frame(7, 2, 2);
    chk("b_busy_fall", b_busy, 0);
    b_en = 1'b0;
    step(3);
    push(9'h15, 1);
    push(9'h2A, 1);
    push(9'h7F, 1);
    chk("b_not_full3", b_full, 0);
    push(9'h03, 1);
    chk("b_full4", b_full, 1);
    chk("b_level4", b_level, 4);
    chk("b_no_ovf", b_ovf, 0);
    push(9'h66, 0);
    chk("b_ovf", b_ovf, 1);
    step(1);
    chk("b_ovf_clear", b_ovf, 0);
    chk("b_level_keep", b_level, 4);
    chk("b_idle_disabled", b_tx, 1);
    b_en = 1'b1;
    for (int k = 0; k < 4; k++) rx_frame(7, 2, 2);
    chk("b_drained", b_empty, 1);
    chk("sb_empty", sb.size(), 0);
`ifdef UART_TX_BREAK_EN
    sel = 1'b0;
    a_brk = 1'b1;
    push(9'h3C, 1);
    chk("brk_low", a_tx, 0);
    chk("brk_busy", a_busy, 1);
    step(1998);
    chk("brk_still_low", a_tx, 0);
    a_brk = 1'b0;
    step(1);
    chk("brk_mark", a_tx, 1);
    begin
      int n = 0;
      while (a_tx === 1'b1 && n < 1000) begin step(1); n++; end
      chk("brk_mark_len", n, CPB);
    end
    rx_frame(8, 0, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
